// File: rtl/qsfp_xcvr_pkg.sv
// Shared types and defaults for the QSFP transceiver reset sequencer.
// Sequencer state encoding is also exported on the debug ports.
package qsfp_xcvr_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT      = 3'd0,
        ST_WAIT_CAL    = 3'd1,
        ST_REL_ANALOG  = 3'd2,
        ST_WAIT_LOCK   = 3'd3,
        ST_REL_DIGITAL = 3'd4,
        ST_READY       = 3'd5
    } seq_state_t;

    localparam int DEF_SYNC_STAGES     = 3;
    localparam int DEF_HOLD_CYC        = 100;
    localparam int DEF_LOCK_STABLE_CYC = 1000;
    localparam int DEF_TIMEOUT_CYC     = 1000000;
    localparam int DEF_CNT_W           = 20;

endpackage

// File: rtl/bit_sync.sv
// Generic multi-flop synchroniser for independent asynchronous level bits.
// Each bit is synchronised on its own; no bus coherency is implied.
module bit_sync #(
    parameter int STAGES = 3,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] ff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/xcvr_reset_dir_fsm.sv
// One direction of the PHY reset sequence: state machine plus the
// hold/timeout counter and the lock-qualification counter.
module xcvr_reset_dir_fsm
    import qsfp_xcvr_pkg::*;
#(
    parameter int HOLD_CYC        = DEF_HOLD_CYC,
    parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
    parameter int TIMEOUT_CYC     = DEF_TIMEOUT_CYC,
    parameter int CNT_W           = DEF_CNT_W,
    parameter bit KEEP_ANALOG     = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       soft_reset,
    input  logic       en_cond,
    input  logic       lock_cond,
    input  logic       cal_busy,
    input  logic       analog_stat,
    input  logic       digital_stat,
    output logic       analogreset,
    output logic       digitalreset,
    output logic       ready,
    output logic [2:0] state_dbg,
    output logic       timeout_hit
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LIM  = CNT_W'(LOCK_STABLE_CYC);
    localparam logic [CNT_W-1:0] TMO_LIM   = CNT_W'(TIMEOUT_CYC);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CNT_W-1:0] tcnt;
    logic [CNT_W-1:0] lock_cnt;
    logic             cal_busy_q;
    logic             hold_done;
    logic             tmo;
    logic             lock_done;
    logic             cal_rise;
    logic             restart;

    assign hold_done = tcnt >= HOLD_LAST;
    assign tmo       = tcnt >= TMO_LIM;
    assign lock_done = lock_cnt >= LOCK_LIM;
    assign cal_rise  = cal_busy & ~cal_busy_q;

    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        if (soft_reset) begin
            state_nxt = ST_ASSERT;
        end else begin
            unique case (state)
                ST_ASSERT: begin
                    if (hold_done && analog_stat && digital_stat) begin
                        state_nxt = ST_WAIT_CAL;
                    end else if (tmo) begin
                        timeout_hit = 1'b1;
                        state_nxt   = ST_ASSERT;
                    end
                end
                ST_WAIT_CAL: begin
                    if (!cal_busy && en_cond) begin
                        state_nxt = ST_REL_ANALOG;
                    end
                end
                ST_REL_ANALOG: begin
                    if (!analog_stat) begin
                        state_nxt = ST_WAIT_LOCK;
                    end else if (tmo) begin
                        timeout_hit = 1'b1;
                        state_nxt   = ST_ASSERT;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_done) begin
                        state_nxt = ST_REL_DIGITAL;
                    end
                end
                ST_REL_DIGITAL: begin
                    if (!digital_stat) begin
                        state_nxt = ST_READY;
                    end else if (tmo) begin
                        timeout_hit = 1'b1;
                        state_nxt   = ST_ASSERT;
                    end
                end
                ST_READY: begin
                    if (cal_rise) begin
                        state_nxt = ST_ASSERT;
                    end else if (!lock_cond) begin
                        // RX keeps the CDR analog path up and only relocks
                        state_nxt = KEEP_ANALOG ? ST_WAIT_LOCK : ST_ASSERT;
                    end
                end
                default: begin
                    state_nxt = ST_ASSERT;
                end
            endcase
        end
    end

    // A timeout re-entry into ASSERT counts as a fresh state visit
    assign restart = soft_reset | timeout_hit | (state_nxt != state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_ASSERT;
            tcnt         <= '0;
            lock_cnt     <= '0;
            cal_busy_q   <= 1'b0;
            analogreset  <= 1'b1;
            digitalreset <= 1'b1;
            ready        <= 1'b0;
        end else begin
            state      <= state_nxt;
            cal_busy_q <= cal_busy;

            if (restart) begin
                tcnt <= '0;
            end else if (tcnt != '1) begin
                tcnt <= tcnt + 1'b1;
            end

            if (state != ST_WAIT_LOCK || restart || !lock_cond) begin
                lock_cnt <= '0;
            end else if (!lock_done) begin
                lock_cnt <= lock_cnt + 1'b1;
            end

            analogreset  <= state_nxt inside {ST_ASSERT, ST_WAIT_CAL};
            digitalreset <= !(state_nxt inside {ST_REL_DIGITAL, ST_READY});
            ready        <= (state == ST_READY) && (state_nxt == ST_READY);
        end
    end

    assign state_dbg = state;

endmodule

// File: rtl/qsfp_xcvr_reset_seq.sv
// Per-channel reset sequencer for the H-tile native PHY: synchronises
// PHY status, runs independent TX and RX sequences, flags stat timeouts.
module qsfp_xcvr_reset_seq
    import qsfp_xcvr_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int HOLD_CYC        = DEF_HOLD_CYC,
    parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
    parameter int TIMEOUT_CYC     = DEF_TIMEOUT_CYC,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       soft_reset_req,
    input  logic       pll_locked,
    input  logic       tx_cal_busy,
    input  logic       rx_cal_busy,
    input  logic       tx_analogreset_stat,
    input  logic       rx_analogreset_stat,
    input  logic       tx_digitalreset_stat,
    input  logic       rx_digitalreset_stat,
    input  logic       rx_is_lockedtodata,
    output logic       tx_analogreset,
    output logic       rx_analogreset,
    output logic       tx_digitalreset,
    output logic       rx_digitalreset,
    output logic       tx_ready,
    output logic       rx_ready,
    output logic [2:0] tx_state,
    output logic [2:0] rx_state,
    output logic       timeout_err
);

    logic [7:0] async_in;
    logic [7:0] sync_in;
    logic       pll_s;
    logic       tx_cal_s;
    logic       rx_cal_s;
    logic       tx_astat_s;
    logic       rx_astat_s;
    logic       tx_dstat_s;
    logic       rx_dstat_s;
    logic       rx_lock_s;
    logic       tx_tmo;
    logic       rx_tmo;

    assign async_in = {pll_locked, tx_cal_busy, rx_cal_busy,
                       tx_analogreset_stat, rx_analogreset_stat,
                       tx_digitalreset_stat, rx_digitalreset_stat,
                       rx_is_lockedtodata};

    bit_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (8)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (async_in),
        .q     (sync_in)
    );

    assign {pll_s, tx_cal_s, rx_cal_s, tx_astat_s, rx_astat_s,
            tx_dstat_s, rx_dstat_s, rx_lock_s} = sync_in;

    xcvr_reset_dir_fsm #(
        .HOLD_CYC        (HOLD_CYC),
        .LOCK_STABLE_CYC (LOCK_STABLE_CYC),
        .TIMEOUT_CYC     (TIMEOUT_CYC),
        .CNT_W           (CNT_W),
        .KEEP_ANALOG     (1'b0)
    ) u_tx (
        .clk          (clk),
        .reset        (reset),
        .soft_reset   (soft_reset_req),
        .en_cond      (pll_s),
        .lock_cond    (pll_s),
        .cal_busy     (tx_cal_s),
        .analog_stat  (tx_astat_s),
        .digital_stat (tx_dstat_s),
        .analogreset  (tx_analogreset),
        .digitalreset (tx_digitalreset),
        .ready        (tx_ready),
        .state_dbg    (tx_state),
        .timeout_hit  (tx_tmo)
    );

    xcvr_reset_dir_fsm #(
        .HOLD_CYC        (HOLD_CYC),
        .LOCK_STABLE_CYC (LOCK_STABLE_CYC),
        .TIMEOUT_CYC     (TIMEOUT_CYC),
        .CNT_W           (CNT_W),
        .KEEP_ANALOG     (1'b1)
    ) u_rx (
        .clk          (clk),
        .reset        (reset),
        .soft_reset   (soft_reset_req),
        .en_cond      (1'b1),
        .lock_cond    (rx_lock_s),
        .cal_busy     (rx_cal_s),
        .analog_stat  (rx_astat_s),
        .digital_stat (rx_dstat_s),
        .analogreset  (rx_analogreset),
        .digitalreset (rx_digitalreset),
        .ready        (rx_ready),
        .state_dbg    (rx_state),
        .timeout_hit  (rx_tmo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_err | tx_tmo | rx_tmo;
        end
    end

endmodule

// File: tb/tb_qsfp_xcvr_reset_seq.sv
// Self-checking bench: PHY ack model, event timestamps and ordering rules
// checked against latencies derived from the sequencing rules.
module tb_qsfp_xcvr_reset_seq;

    localparam int SYNC = 2;
    localparam int HOLD = 4;
    localparam int LOCK = 8;
    localparam int TMO  = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic soft_reset_req = 1'b0;
    logic pll_locked = 1'b1;
    logic tx_cal_busy = 1'b0;
    logic rx_cal_busy = 1'b0;
    logic rx_is_lockedtodata = 1'b1;
    logic tx_analogreset_stat = 1'b0;
    logic rx_analogreset_stat = 1'b0;
    logic tx_digitalreset_stat = 1'b0;
    logic rx_digitalreset_stat = 1'b0;
    logic tx_analogreset, rx_analogreset, tx_digitalreset, rx_digitalreset;
    logic tx_ready, rx_ready, timeout_err;
    logic [2:0] tx_state, rx_state;

    always #5 clk = ~clk;

    qsfp_xcvr_reset_seq #(
        .SYNC_STAGES     (SYNC),
        .HOLD_CYC        (HOLD),
        .LOCK_STABLE_CYC (LOCK),
        .TIMEOUT_CYC     (TMO),
        .CNT_W           (20)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .soft_reset_req       (soft_reset_req),
        .pll_locked           (pll_locked),
        .tx_cal_busy          (tx_cal_busy),
        .rx_cal_busy          (rx_cal_busy),
        .tx_analogreset_stat  (tx_analogreset_stat),
        .rx_analogreset_stat  (rx_analogreset_stat),
        .tx_digitalreset_stat (tx_digitalreset_stat),
        .rx_digitalreset_stat (rx_digitalreset_stat),
        .rx_is_lockedtodata   (rx_is_lockedtodata),
        .tx_analogreset       (tx_analogreset),
        .rx_analogreset       (rx_analogreset),
        .tx_digitalreset      (tx_digitalreset),
        .rx_digitalreset      (rx_digitalreset),
        .tx_ready             (tx_ready),
        .rx_ready             (rx_ready),
        .tx_state             (tx_state),
        .rx_state             (rx_state),
        .timeout_err          (timeout_err)
    );

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // PHY model: each stat follows its reset 3 cycles later
    logic [2:0] p_ta = '0, p_ra = '0, p_td = '0, p_rd = '0;
    bit tx_an_stuck = 1'b0;
    int unsigned tx_as_fall = 0, rx_as_fall = 0;
    int unsigned tx_a_fall = 0, rx_a_fall = 0, tx_d_fall = 0, rx_d_fall = 0;
    int viol = 0, rx_a_rise = 0, tx_s0_entries = 0;
    logic pr_tx_a = 1'b1, pr_rx_a = 1'b1, pr_tx_d = 1'b1, pr_rx_d = 1'b1;
    logic [2:0] pr_tx_st = '0;

    always @(negedge clk) begin
        logic nv;
        nv = tx_an_stuck ? 1'b1 : p_ta[2];
        if (tx_analogreset_stat && !nv) tx_as_fall = cyc;
        tx_analogreset_stat = nv;
        nv = p_ra[2];
        if (rx_analogreset_stat && !nv) rx_as_fall = cyc;
        rx_analogreset_stat = nv;
        tx_digitalreset_stat = p_td[2];
        rx_digitalreset_stat = p_rd[2];
        p_ta = {p_ta[1:0], tx_analogreset};
        p_ra = {p_ra[1:0], rx_analogreset};
        p_td = {p_td[1:0], tx_digitalreset};
        p_rd = {p_rd[1:0], rx_digitalreset};

        if (tx_analogreset && !tx_digitalreset) viol++;
        if (rx_analogreset && !rx_digitalreset) viol++;
        if (tx_state == 3'd0 && !(tx_analogreset && tx_digitalreset)) viol++;
        if (rx_state == 3'd0 && !(rx_analogreset && rx_digitalreset)) viol++;
        if (tx_ready && (tx_analogreset || tx_digitalreset)) viol++;
        if (rx_ready && (rx_analogreset || rx_digitalreset)) viol++;

        if (pr_tx_a && !tx_analogreset) tx_a_fall = cyc;
        if (pr_rx_a && !rx_analogreset) rx_a_fall = cyc;
        if (pr_tx_d && !tx_digitalreset) tx_d_fall = cyc;
        if (pr_rx_d && !rx_digitalreset) rx_d_fall = cyc;
        if (!pr_rx_a && rx_analogreset) rx_a_rise++;
        if (tx_state == 3'd0 && pr_tx_st != 3'd0) tx_s0_entries++;
        pr_tx_a = tx_analogreset;
        pr_rx_a = rx_analogreset;
        pr_tx_d = tx_digitalreset;
        pr_rx_d = rx_digitalreset;
        pr_tx_st = tx_state;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        step(5);
        reset = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        for (int i = 0; i < budget && !(tx_ready && rx_ready); i++)
            @(negedge clk);
        chk(tag, 32'({tx_ready, rx_ready}), 32'(2'b11));
    endtask

    function automatic logic [31:0] outs();
        return 32'({tx_analogreset, rx_analogreset, tx_digitalreset,
                    rx_digitalreset, tx_ready, rx_ready, timeout_err,
                    tx_state, rx_state});
    endfunction

    localparam logic [12:0] RST_OUTS = {4'hF, 2'b00, 1'b0, 3'd0, 3'd0};

    initial begin
        int n;
        int k;
        int e0;
        int ra0;
        int unsigned g;
        int unsigned c;

        step(5);
        chk("reset_outs", outs(), 32'(RST_OUTS));

        reset = 1'b0;
        wait_ready("nom_ready", 300);
        chk("nom_tx_dig_lat", tx_d_fall - tx_as_fall, LOCK + SYNC + 2);
        chk("nom_rx_dig_lat", rx_d_fall - rx_as_fall, LOCK + SYNC + 2);
        chk("nom_tx_order", 32'(tx_a_fall < tx_d_fall), 32'd1);
        chk("nom_rx_order", 32'(rx_a_fall < rx_d_fall), 32'd1);
        chk("nom_states", 32'({tx_state, rx_state}), 32'({3'd5, 3'd5}));
        chk("nom_timeout", 32'(timeout_err), 32'd0);

        n = $urandom_range(150, 250);
        rx_cal_busy = 1'b1;
        do_reset();
        step(n);
        chk("cal_hold", 32'({rx_state, rx_analogreset, rx_digitalreset,
                             timeout_err, tx_ready}),
            32'({3'd1, 1'b1, 1'b1, 1'b0, 1'b1}));
        rx_cal_busy = 1'b0;
        c = cyc;
        for (int i = 0; i < 20 && rx_analogreset; i++) @(negedge clk);
        chk("cal_rel_lat", cyc - c, SYNC + 1);
        wait_ready("cal_ready", 100);

        for (int t = 0; t < 3; t++) begin
            k = $urandom_range(2, 5);
            do_reset();
            for (int i = 0; i < 100 && rx_state != 3'd3; i++)
                @(negedge clk);
            chk("glitch_reach", 32'(rx_state), 32'd3);
            step(k);
            rx_is_lockedtodata = 1'b0;
            g = cyc;
            step(1);
            rx_is_lockedtodata = 1'b1;
            for (int i = 0; i < 60 && rx_digitalreset; i++) @(negedge clk);
            chk("glitch_dig_lat", cyc - g, LOCK + SYNC + 2);
            wait_ready("glitch_ready", 100);
        end

        step(3);
        ra0 = rx_a_rise;
        rx_is_lockedtodata = 1'b0;
        step(SYNC);
        chk("loss_early", 32'({rx_ready, rx_digitalreset}), 32'(2'b10));
        step(1);
        chk("loss_rx", 32'({rx_digitalreset, rx_ready, rx_analogreset,
                            rx_state}), 32'({1'b1, 1'b0, 1'b0, 3'd3}));
        chk("loss_tx", 32'({tx_ready, tx_state, tx_digitalreset}),
            32'({1'b1, 3'd5, 1'b0}));
        step($urandom_range(5, 40));
        rx_is_lockedtodata = 1'b1;
        wait_ready("loss_recover", 60);
        chk("loss_no_analog", rx_a_rise - ra0, 0);

        tx_an_stuck = 1'b1;
        do_reset();
        for (int i = 0; i < 100 && tx_state != 3'd2; i++) @(negedge clk);
        chk("tmo_reach", 32'(tx_state), 32'd2);
        step(TMO);
        chk("tmo_before", 32'({timeout_err, tx_state}), 32'({1'b0, 3'd2}));
        step(1);
        chk("tmo_set", 32'({timeout_err, tx_state}), 32'({1'b1, 3'd0}));
        e0 = tx_s0_entries;
        step(300);
        chk("tmo_repeat", 32'((tx_s0_entries - e0) >= 2), 32'd1);
        chk("tmo_rx_ready", 32'({rx_ready, rx_state}), 32'({1'b1, 3'd5}));
        chk("tmo_sticky", 32'(timeout_err), 32'd1);
        tx_an_stuck = 1'b0;
        wait_ready("tmo_recover", 300);
        chk("tmo_sticky2", 32'(timeout_err), 32'd1);

        do_reset();
        for (int i = 0; i < 100 && tx_state != 3'd3; i++) @(negedge clk);
        chk("soft_reach", 32'(tx_state), 32'd3);
        soft_reset_req = 1'b1;
        step(1);
        soft_reset_req = 1'b0;
        chk("soft_outs", outs(), 32'(RST_OUTS));
        wait_ready("soft_recover", 300);
        chk("soft_tmo", 32'(timeout_err), 32'd0);

        step(2);
        #1 reset = 1'b1;
        #1 chk("async_outs", outs(), 32'(RST_OUTS));
        step(3);
        reset = 1'b0;
        wait_ready("async_recover", 300);

        chk("invariants", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
